// File: rtl/conv_channel_sequencer_if.sv
// Frame-memory read port and convolution-engine stream shared by the channel sequencer.
interface conv_channel_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  conv_valid_in;
  logic [DATA_WIDTH-1:0] conv_data_in;
  logic                  conv_done;

  modport master (
    output mem_rd_en, mem_rd_addr, conv_valid_in, conv_data_in,
    input  mem_rd_data, conv_done
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, conv_valid_in, conv_data_in,
    output mem_rd_data, conv_done
  );
endinterface

// File: rtl/conv_channel_sequencer.sv
// Streams each channel of a frame from memory into a convolution engine, pads each
// channel with IMG_WIDTH+1 zero pixels, then waits (with timeout) for the engine's done pulse.
module conv_channel_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMG_WIDTH  = 56,
  parameter int unsigned IMG_HEIGHT = 56,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic                            abort,
  conv_channel_sequencer_if.master        bus,
  output logic                            busy,
  output logic [7:0]                      ch_idx,
  output logic                            ch_start,
  output logic                            layer_done,
  output logic                            timeout_err
);

  localparam int unsigned P       = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned CNT_MAX = (P > IMG_WIDTH + 1) ? P : IMG_WIDTH + 1;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, FEED, FLUSH, WAIT_DONE, NEXT} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         pix_cnt;
  logic [TW-1:0]         wait_cnt;
  logic                  done_seen;
  logic                  valid_q;
  logic                  rd_q;
  logic                  flush_issue;
  logic                  last_pix, last_flush, last_ch, timeout_fire;
  logic [31:0]           addr_full;
  logic [DATA_WIDTH-1:0] rd_data;

  assign last_pix   = (pix_cnt == CW'(P - 1));
  assign last_flush = (pix_cnt == CW'(IMG_WIDTH));
  assign last_ch    = (ch_idx == 8'(NUM_CH - 1));
  assign addr_full  = 32'(ch_idx) * 32'(P) + 32'(pix_cnt);
  assign rd_data    = bus.mem_rd_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next      = state;
    busy            = (state != IDLE);
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    flush_issue     = 1'b0;
    ch_start        = 1'b0;
    layer_done      = 1'b0;
    timeout_fire    = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = FEED;
      FEED: begin
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = addr_full[ADDR_WIDTH-1:0];
        ch_start        = (pix_cnt == '0);
        if (last_pix) state_next = FLUSH;
      end
      FLUSH: begin
        flush_issue = 1'b1;
        if (last_flush) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_seen) begin
          state_next = NEXT;
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          timeout_fire = !abort;
          state_next   = IDLE;
        end
      end
      NEXT: begin
        layer_done = last_ch;
        state_next = last_ch ? IDLE : FEED;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides every transition, including the timeout exit.
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_cnt     <= '0;
      wait_cnt    <= '0;
      done_seen   <= 1'b0;
      ch_idx      <= '0;
      timeout_err <= 1'b0;
      valid_q     <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      valid_q <= bus.mem_rd_en | flush_issue;
      rd_q    <= bus.mem_rd_en;
      if (abort) begin
        pix_cnt   <= '0;
        wait_cnt  <= '0;
        done_seen <= 1'b0;
        ch_idx    <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            ch_idx      <= '0;
            pix_cnt     <= '0;
            wait_cnt    <= '0;
            done_seen   <= 1'b0;
            timeout_err <= 1'b0;
          end
          FEED: pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
          FLUSH: begin
            pix_cnt  <= last_flush ? '0 : pix_cnt + 1'b1;
            wait_cnt <= '0;
            if (bus.conv_done) done_seen <= 1'b1;
          end
          WAIT_DONE: begin
            if (bus.conv_done) done_seen <= 1'b1;
            if (timeout_fire) begin
              timeout_err <= 1'b1;
              wait_cnt    <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          NEXT: begin
            done_seen <= 1'b0;
            wait_cnt  <= '0;
            if (!last_ch) ch_idx <= ch_idx + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.conv_valid_in = valid_q;
  assign bus.conv_data_in  = rd_q ? rd_data : '0;

endmodule
